// File: rtl/ex_stage.sv
// Execute stage of the five-stage LoongArch32 pipeline: pipeline register, one-hot ALU,
// data-SRAM request generation and the EX->MEM / EX->ID buses.
module ex_stage (
    input  logic         clk,
    input  logic         reset,
    input  logic         id_to_ex_valid,
    output logic         ex_allowin,
    input  logic [147:0] id_to_ex_bus,
    input  logic         mem_allowin,
    output logic         ex_to_mem_valid,
    output logic [70:0]  ex_to_mem_bus,
    output logic [38:0]  ex_to_id_bus,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);

    logic        ex_valid;
    logic        ex_ready_go;
    logic [11:0] alu_op;
    logic        res_from_mem;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        mem_we;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rkd_value;
    logic [31:0] pc;

    logic [31:0] alu_result;
    logic [4:0]  shamt;
    logic        valid_rf_we;
    logic        valid_res_from_mem;

    assign ex_ready_go     = 1'b1;
    assign ex_allowin      = ~ex_valid | (ex_ready_go & mem_allowin);
    assign ex_to_mem_valid = ex_valid & ex_ready_go;

    // EX never flushes; only reset can drop a captured bundle
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            alu_op       <= 12'd0;
            res_from_mem <= 1'b0;
            src1         <= 32'd0;
            src2         <= 32'd0;
            mem_we       <= 1'b0;
            rf_we        <= 1'b0;
            rf_waddr     <= 5'd0;
            rkd_value    <= 32'd0;
            pc           <= 32'd0;
        end else begin
            if (ex_allowin) begin
                ex_valid <= id_to_ex_valid;
            end
            if (id_to_ex_valid & ex_allowin) begin
                {alu_op, res_from_mem, src1, src2, mem_we, rf_we,
                 rf_waddr, rkd_value, pc} <= id_to_ex_bus;
            end
        end
    end

    assign shamt = src2[4:0];

    // Each operation contributes only when its one-hot bit is set; results are ORed
    always_comb begin
        alu_result = 32'd0;
        if (alu_op[0])  alu_result = alu_result | (src1 + src2);
        if (alu_op[1])  alu_result = alu_result | (src1 - src2);
        if (alu_op[2])  alu_result = alu_result | {31'd0, $signed(src1) < $signed(src2)};
        if (alu_op[3])  alu_result = alu_result | {31'd0, src1 < src2};
        if (alu_op[4])  alu_result = alu_result | (src1 & src2);
        if (alu_op[5])  alu_result = alu_result | ~(src1 | src2);
        if (alu_op[6])  alu_result = alu_result | (src1 | src2);
        if (alu_op[7])  alu_result = alu_result | (src1 ^ src2);
        if (alu_op[8])  alu_result = alu_result | (src1 << shamt);
        if (alu_op[9])  alu_result = alu_result | (src1 >> shamt);
        if (alu_op[10]) alu_result = alu_result | 32'($signed(src1) >>> shamt);
        if (alu_op[11]) alu_result = alu_result | src2;
    end

    // A bubble must never claim a register write or a load on either bus
    assign valid_rf_we        = rf_we & ex_valid;
    assign valid_res_from_mem = res_from_mem & ex_valid;

    assign ex_to_mem_bus = {valid_res_from_mem, valid_rf_we, rf_waddr, alu_result, pc};
    assign ex_to_id_bus  = {valid_res_from_mem, valid_rf_we, rf_waddr, alu_result};

    assign data_sram_en    = ex_valid & (res_from_mem | mem_we);
    assign data_sram_we    = {4{ex_valid & mem_we}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed test-plan steps followed by randomized traffic,
// all compared against a field-level reference model of the pipeline register and ALU.
module tb_ex_stage;

    typedef struct {
        logic [11:0] op;
        logic        rfm;
        logic [31:0] s1;
        logic [31:0] s2;
        logic        mw;
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] rkd;
        logic [31:0] pc;
    } bundle_t;

    logic         clk;
    logic         reset;
    logic         id_to_ex_valid;
    logic         ex_allowin;
    logic [147:0] id_to_ex_bus;
    logic         mem_allowin;
    logic         ex_to_mem_valid;
    logic [70:0]  ex_to_mem_bus;
    logic [38:0]  ex_to_id_bus;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int vectors = 0;
    int miscompares = 0;

    logic    m_valid;
    bundle_t m_b;
    bundle_t drv;

    ex_stage dut (
        .clk             (clk),
        .reset           (reset),
        .id_to_ex_valid  (id_to_ex_valid),
        .ex_allowin      (ex_allowin),
        .id_to_ex_bus    (id_to_ex_bus),
        .mem_allowin     (mem_allowin),
        .ex_to_mem_valid (ex_to_mem_valid),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_id_bus    (ex_to_id_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bundle_t zero_bundle();
        bundle_t z;
        z.op = '0; z.rfm = 0; z.s1 = '0; z.s2 = '0; z.mw = 0;
        z.rw = 0; z.wa = '0; z.rkd = '0; z.pc = '0;
        return z;
    endfunction

    function automatic logic [147:0] pack(bundle_t b);
        return {b.op, b.rfm, b.s1, b.s2, b.mw, b.rw, b.wa, b.rkd, b.pc};
    endfunction

    // Reference ALU written with plain integer arithmetic
    function automatic logic [31:0] alu_ref(bundle_t b);
        logic [31:0] r;
        longint unsigned a;
        longint unsigned c;
        int sh;
        r = 32'd0;
        a = longint'(b.s1);
        c = longint'(b.s2);
        sh = int'(b.s2 % 32);
        if (b.op[0])  r |= 32'(a + c);
        if (b.op[1])  r |= 32'(a - c);
        if (b.op[2])  r |= (int'(b.s1) < int'(b.s2)) ? 32'd1 : 32'd0;
        if (b.op[3])  r |= (a < c) ? 32'd1 : 32'd0;
        if (b.op[4])  r |= b.s1 & b.s2;
        if (b.op[5])  r |= ~(b.s1 | b.s2);
        if (b.op[6])  r |= b.s1 | b.s2;
        if (b.op[7])  r |= b.s1 ^ b.s2;
        if (b.op[8])  r |= 32'(a * (64'd1 << sh));
        if (b.op[9])  r |= 32'(a / (64'd1 << sh));
        if (b.op[10]) r |= 32'(a / (64'd1 << sh)) | (b.s1[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
        if (b.op[11]) r |= b.s2;
        return r;
    endfunction

    task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input bundle_t b, input logic mem_ok, input logic rst);
        id_to_ex_valid = v;
        drv            = b;
        id_to_ex_bus   = pack(b);
        mem_allowin    = mem_ok;
        reset          = rst;
    endtask

    // Advance one clock, updating the model from the inputs seen at that edge
    task automatic tick();
        logic    nv;
        bundle_t nb;
        logic    allow;
        nv = m_valid;
        nb = m_b;
        allow = !m_valid || mem_allowin;
        if (reset) begin
            nv = 1'b0;
            nb = zero_bundle();
        end else begin
            if (allow) nv = id_to_ex_valid;
            if (allow && id_to_ex_valid) nb = drv;
        end
        @(posedge clk);
        #1;
        m_valid = nv;
        m_b = nb;
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] res;
        logic        v;
        v = m_valid;
        res = alu_ref(m_b);
        check({tag, ".allowin"}, 71'(ex_allowin), 71'(!v || mem_allowin));
        check({tag, ".mem_valid"}, 71'(ex_to_mem_valid), 71'(v));
        check({tag, ".mem_bus"}, ex_to_mem_bus,
              {m_b.rfm & v, m_b.rw & v, m_b.wa, res, m_b.pc});
        check({tag, ".id_bus"}, 71'(ex_to_id_bus),
              71'({m_b.rfm & v, m_b.rw & v, m_b.wa, res}));
        check({tag, ".sram_en"}, 71'(data_sram_en), 71'(v && (m_b.rfm || m_b.mw)));
        check({tag, ".sram_we"}, 71'(data_sram_we), 71'((v && m_b.mw) ? 4'hF : 4'h0));
        check({tag, ".sram_addr"}, 71'(data_sram_addr), 71'(res));
        check({tag, ".sram_wdata"}, 71'(data_sram_wdata), 71'(m_b.rkd));
    endtask

    bundle_t     b;
    bundle_t     ba;
    bundle_t     bb;
    logic [31:0] sweep_exp [11];
    logic [31:0] a_res;

    initial begin
        sweep_exp = '{32'h8000_0004, 32'h7FFF_FFFE, 32'h0000_0001, 32'h0000_0000,
                      32'h0000_0001, 32'h7FFF_FFFC, 32'h8000_0003, 32'h8000_0002,
                      32'h0000_0008, 32'h1000_0000, 32'hF000_0000};
        m_valid = 1'b0;
        m_b = zero_bundle();
        drv = zero_bundle();

        // Reset for two cycles, then idle
        applyStimulus(1'b0, zero_bundle(), 1'b1, 1'b1);
        tick();
        tick();
        reset = 1'b0;
        checkOutput("reset");
        check("reset.allowin_lit", 71'(ex_allowin), 71'(1));
        check("reset.mem_valid_lit", 71'(ex_to_mem_valid), 71'(0));
        check("reset.sram_en_lit", 71'(data_sram_en), 71'(0));
        check("reset.id_bus_lit", 71'(ex_to_id_bus), 71'(0));
        tick();
        checkOutput("idle");

        // ALU sweep
        for (int i = 0; i < 11; i++) begin
            b = zero_bundle();
            b.op = 12'd1 << i;
            b.s1 = 32'h8000_0001;
            b.s2 = 32'h0000_0003;
            b.rw = 1'b1;
            b.wa = 5'(i + 1);
            b.pc = $urandom;
            applyStimulus(1'b1, b, 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("sweep%0d", i));
            check($sformatf("sweep%0d.result_lit", i), 71'(ex_to_mem_bus[63:32]), 71'(sweep_exp[i]));
        end
        b = zero_bundle();
        b.op = 12'h800;
        b.s1 = $urandom;
        b.s2 = 32'h1234_5000;
        b.rw = 1'b1;
        applyStimulus(1'b1, b, 1'b1, 1'b0);
        tick();
        checkOutput("lui");
        check("lui.result_lit", 71'(ex_to_mem_bus[63:32]), 71'(32'h1234_5000));

        // Store
        b = zero_bundle();
        b.op = 12'h001;
        b.s1 = 32'h1C00_0000;
        b.s2 = 32'h10;
        b.mw = 1'b1;
        b.rkd = 32'hDEAD_BEEF;
        applyStimulus(1'b1, b, 1'b1, 1'b0);
        tick();
        checkOutput("store");
        check("store.en_lit", 71'(data_sram_en), 71'(1));
        check("store.we_lit", 71'(data_sram_we), 71'(4'hF));
        check("store.addr_lit", 71'(data_sram_addr), 71'(32'h1C00_0010));
        check("store.wdata_lit", 71'(data_sram_wdata), 71'(32'hDEAD_BEEF));
        check("store.rf_we_lit", 71'(ex_to_mem_bus[69]), 71'(0));

        // Load followed by a bubble
        b = zero_bundle();
        b.op = 12'h001;
        b.rfm = 1'b1;
        b.rw = 1'b1;
        b.wa = 5'd5;
        b.s1 = 32'h1C00_0000;
        b.s2 = 32'h20;
        applyStimulus(1'b1, b, 1'b1, 1'b0);
        tick();
        checkOutput("load");
        check("load.id_bus_lit", 71'(ex_to_id_bus), 71'({1'b1, 1'b1, 5'd5, 32'h1C00_0020}));
        check("load.en_lit", 71'(data_sram_en), 71'(1));
        check("load.we_lit", 71'(data_sram_we), 71'(0));
        applyStimulus(1'b0, zero_bundle(), 1'b1, 1'b0);
        tick();
        checkOutput("load_bubble");
        check("load_bubble.flags_lit", 71'(ex_to_id_bus[38:37]), 71'(0));

        // Back-pressure with a second bundle waiting in ID
        ba = zero_bundle();
        ba.op = 12'h001;
        ba.s1 = 32'h0000_1000;
        ba.s2 = 32'h0000_0234;
        ba.rw = 1'b1;
        ba.wa = 5'd9;
        ba.pc = 32'h1C00_0100;
        a_res = 32'h0000_1234;
        applyStimulus(1'b1, ba, 1'b1, 1'b0);
        tick();
        checkOutput("bp_a");
        bb = ba;
        bb.op = 12'h040;
        bb.wa = 5'd10;
        bb.pc = 32'h1C00_0104;
        applyStimulus(1'b1, bb, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("bp_hold%0d", i));
            check($sformatf("bp_hold%0d.allowin_lit", i), 71'(ex_allowin), 71'(0));
            check($sformatf("bp_hold%0d.bus_lit", i), ex_to_mem_bus,
                  {1'b0, 1'b1, 5'd9, a_res, 32'h1C00_0100});
        end
        mem_allowin = 1'b1;
        tick();
        checkOutput("bp_release");
        check("bp_release.pc_lit", 71'(ex_to_mem_bus[31:0]), 71'(32'h1C00_0104));
        applyStimulus(1'b0, zero_bundle(), 1'b1, 1'b0);
        tick();
        checkOutput("bp_drain");
        check("bp_drain.valid_lit", 71'(ex_to_mem_valid), 71'(0));

        // Reset while a store is in EX
        b = zero_bundle();
        b.op = 12'h001;
        b.s1 = 32'h1C00_0000;
        b.s2 = 32'h40;
        b.mw = 1'b1;
        b.rkd = 32'h1234_5678;
        applyStimulus(1'b1, b, 1'b1, 1'b0);
        tick();
        checkOutput("rst_mid_pre");
        applyStimulus(1'b1, b, 1'b0, 1'b1);
        tick();
        reset = 1'b0;
        id_to_ex_valid = 1'b0;
        checkOutput("rst_mid");
        check("rst_mid.valid_lit", 71'(ex_to_mem_valid), 71'(0));
        check("rst_mid.we_lit", 71'(data_sram_we), 71'(0));

        // Randomized traffic with occasional reset
        for (int n = 0; n < 300; n++) begin
            int k;
            b = zero_bundle();
            k = int'($urandom_range(0, 12));
            b.op = (k == 12) ? 12'd0 : (12'd1 << k);
            b.rfm = 1'($urandom);
            b.s1 = $urandom;
            b.s2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            b.mw = 1'($urandom);
            b.rw = 1'($urandom);
            b.wa = 5'($urandom);
            b.rkd = $urandom;
            b.pc = $urandom;
            applyStimulus(1'($urandom), b, ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 31) == 0));
            tick();
            checkOutput($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage in-order LoongArch32 CPU (IF, ID, EX, MEM, WB). It accepts a decoded instruction bundle from the decode stage through a valid/allowin handshake and holds it in a pipeline register. It evaluates the 12-way one-hot ALU operation, issues the data-SRAM request for `ld.w` and `st.w`, and forwards the bundle to the memory stage. It also publishes its destination register and result back to decode for bypassing and load-use stall detection.

## Interface
- No parameters.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `id_to_ex_valid` input 1: decode offers a bundle.
- `ex_allowin` output 1: EX can accept a bundle this cycle.
- `id_to_ex_bus` input 148: {alu_op[11:0], res_from_mem, src1[31:0], src2[31:0], mem_we, rf_we, rf_waddr[4:0], rkd_value[31:0], pc[31:0]}, MSB first.
- `mem_allowin` input 1: memory stage can accept.
- `ex_to_mem_valid` output 1: EX offers a bundle to MEM.
- `ex_to_mem_bus` output 71: {res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0], pc[31:0]}.
- `ex_to_id_bus` output 39: {res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0]}.
- `data_sram_en` output 1: data SRAM access enable.
- `data_sram_we` output 4: byte write enables.
- `data_sram_addr` output 32: byte address.
- `data_sram_wdata` output 32: store data.

## Operation
- Pipeline register: holds `ex_valid` plus all 148 bundle bits.
- `ex_ready_go` is constant 1, so every ALU operation completes in a single cycle.
- `ex_allowin = ~ex_valid | (ex_ready_go & mem_allowin)`.
- `ex_to_mem_valid = ex_valid & ex_ready_go`.
- ALU operations, one-hot on `alu_op`; src1 and src2 are the registered values:
  - bit 0 add: src1+src2, mod 2^32.
  - bit 1 sub: src1-src2, mod 2^32.
  - bit 2 slt: signed less-than; result is {31'b0, lt}.
  - bit 3 sltu: unsigned less-than; result is {31'b0, lt}.
  - bit 4 and; bit 5 nor; bit 6 or; bit 7 xor.
  - bit 8 sll: src1 << src2[4:0].
  - bit 9 srl: logical right shift by src2[4:0].
  - bit 10 sra: arithmetic right shift by src2[4:0].
  - bit 11 lui: result = src2.
  - All-zero `alu_op` gives result 0. Results of all set bits are ORed together; decode guarantees at most one bit is set.
- Overflow is ignored. Shift amounts are taken from src2[4:0] only.
- Data SRAM request:
  - `data_sram_en = ex_valid & (res_from_mem | mem_we)`.
  - `data_sram_we = {4{ex_valid & mem_we}}`.
  - `data_sram_addr = alu_result`.
  - `data_sram_wdata = rkd_value`.
- Outgoing qualification: `rf_we` and `res_from_mem` on both output buses are ANDed with `ex_valid`. A bubble therefore never claims a register write or a load.
- `ex_to_id_bus` is combinational from the EX register contents. Decode stalls whenever this bus shows `res_from_mem=1` and the register matches one it needs.
- EX never flushes. Branches resolve in ID, so a bundle that enters EX always commits.

## Timing
- Reset values:
  - `ex_valid` and all bundle registers are 0.
  - Outputs after reset: `ex_allowin`=1, `ex_to_mem_valid`=0, `data_sram_en`=0, `data_sram_we`=0, `data_sram_addr`=0, `data_sram_wdata`=0, and both output buses are all-zero.
- Capture rule:
  - When `ex_allowin` is high at a clock edge, `ex_valid` loads `id_to_ex_valid`.
  - The bundle register loads only when `id_to_ex_valid & ex_allowin`.
  - When the bundle register does not load, it holds.
- Latency: a bundle captured at edge N is presented to MEM, the SRAM and the ID bypass during cycle N to N+1. Load data returns from the synchronous SRAM at edge N+1, in MEM.
- Back-pressure (`mem_allowin`=0 with `ex_valid`=1):
  - The bundle holds and the SRAM request is re-presented each cycle.
  - Repeated identical reads and writes are idempotent.
- `id_to_ex_valid`=0 with `ex_allowin`=1: a bubble enters and `ex_valid` becomes 0.
- Reset asserted mid-stream: the next edge clears `ex_valid` regardless of the handshake, and the in-flight bundle is dropped.

## Test plan
- Reset, then idle:
  - Hold `reset`=1 for 2 cycles, then release with `id_to_ex_valid`=0.
  - Required: `ex_allowin`=1, `ex_to_mem_valid`=0, `data_sram_en`=0, `ex_to_id_bus`=0.
- Full ALU sweep, each operation with `mem_allowin`=1:
  - src1=0x80000001 and src2=0x00000003 for add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra.
  - Required results: add 0x80000004, sub 0x7FFFFFFE, slt 1, sltu 0, and 1, nor 0x7FFFFFFC, or 0x80000003, xor 0x80000002, sll 0x00000008, srl 0x10000000, sra 0xF0000000.
  - Separately, lui with src2=0x12345000 gives 0x12345000.
- Store:
  - st.w with src1=0x1C000000, src2=0x10, rkd_value=0xDEADBEEF.
  - Required in the following cycle: `data_sram_en`=1, `data_sram_we`=0xF, `data_sram_addr`=0x1C000010, `data_sram_wdata`=0xDEADBEEF, and `ex_to_mem_bus` rf_we=0.
- Load bypass:
  - ld.w with rf_waddr=5 and address 0x1C000020.
  - Required: `data_sram_en`=1, `data_sram_we`=0, and `ex_to_id_bus`={1,1,5'd5,0x1C000020} for exactly one cycle.
  - With a bubble behind it, the bus drops to res_from_mem=0 and rf_we=0 the next cycle.
- Back-pressure:
  - Hold `mem_allowin`=0 for 3 cycles with a valid add in EX while ID keeps offering a second bundle.
  - Required: `ex_allowin`=0, the EX bundle unchanged, and the second bundle not captured.
  - After release, the second bundle enters on the next edge with no loss or duplication.
- Reset mid-operation:
  - Assert `reset` while EX holds a valid st.w.
  - Required: `ex_to_mem_valid`=0 and `data_sram_we`=0 after the next edge.
